ocx_dlx_rx_lane_sync_det: RTL and testbench
===========================================

Name: ocx_dlx_rx_lane_sync_det

Overview:
Per-lane sync-pattern detector for the 8-lane Xilinx PHY receive path. It sits directly upstream of the transceiver retrain sequencer.
- Consumes the init-gated lane valid/data from the PHY.
- Counts consecutive sync-pattern beats per lane.
- Drives pb_io_o0_rx_run_lane; the sequencer ANDs this vector to trigger the receiver datapath reset.
- Enforces a lane-to-lane lock timeout and supports a retrain clear.

Parameters:
DW, 32, lane data width per beat
SYNC_PATTERN, 32'h4B4B_4B4B, beat value that counts as a sync match (width DW)
SYNC_CNT, 4, consecutive matching valid beats required to lock a lane (legal range 1..15)
TIMEOUT_CYC, 1024, cycles allowed between first lane locked and all lanes locked (legal range 2..65535)

Ports:
opt_gckn  input  1  Rx-domain clock, all logic on rising edge
dlx_reset_n  input  1  asynchronous active-low reset
ln_rx_valid  input  8  per-lane beat valid, bit i = lane i (already gated by PHY rx init)
ln_rx_data  input  8*DW  lane i data at [i*DW +: DW]
retrain  input  1  synchronous level clear; any cycle high clears all lanes
pb_io_o0_rx_run_lane  output  8  per-lane locked flag, registered
sync_timeout  output  1  one-cycle pulse when lock timeout fires, registered
lanes_locked_cnt  output  4  popcount of pb_io_o0_rx_run_lane (0..8), combinational from registers

Behaviour:
Reset:
- dlx_reset_n low: immediate async clear of all lane FSMs to SEARCH, match counters to 0, timer to 0.
- Outputs in reset: pb_io_o0_rx_run_lane=8'h00, sync_timeout=0, lanes_locked_cnt=0.

Per-lane FSM (independent per lane):
- States: SEARCH, COUNT, LOCKED.
- Match is defined as ln_rx_data lane slice == SYNC_PATTERN.
- SEARCH:
  - valid&match: go to COUNT with cnt=1, or go directly to LOCKED if SYNC_CNT==1.
  - Otherwise stay in SEARCH.
- COUNT:
  - valid&match: cnt+1; when the new cnt equals SYNC_CNT, go to LOCKED.
  - valid&mismatch: go to SEARCH, cnt=0. A mismatching beat does not count as a first match.
  - valid low: hold state and cnt unchanged.
- LOCKED:
  - Sticky; data and valid are ignored.
  - Leaves only on a global clear.
- Match counter is 4 bits and never wraps (bounded by SYNC_CNT).
- run_lane bit i = 1 iff lane i is in LOCKED. It rises on the clock edge that captures the SYNC_CNT-th matching beat, i.e. latency is 1 cycle from beat presentation.

Lock timer (16 bits):
- partial = (run_lane != 8'h00) & (run_lane != 8'hFF).
- partial and timer == TIMEOUT_CYC-1: raise timeout_clear. Next edge: all lanes go to SEARCH, cnt=0, timer=0, sync_timeout=1 for exactly one cycle.
- partial, otherwise: timer+1.
- Not partial (none or all locked): timer=0.

Global clear priority, highest first:
1. Async reset.
2. retrain: all lanes to SEARCH, timer=0. sync_timeout is NOT pulsed, even if a timeout coincides.
3. timeout_clear.
4. Normal FSM update.

Simultaneous events:
- A lane completing lock in the same cycle as a clear: the clear wins and the lane goes to SEARCH.
- The last lane locking in the same cycle the timer reaches TIMEOUT_CYC-1: timeout_clear is evaluated on the pre-edge run_lane (still partial), so the timeout fires and all lanes clear.
- retrain held high: all lanes stay in SEARCH with run_lane=0. Matching resumes on the first cycle after retrain goes low.

Other rules:
- sync_timeout never asserts on two consecutive cycles. After a clear, run_lane=0, so partial=0.
- lanes_locked_cnt is a pure function of the run_lane register. There is no extra latency.

Test Plan:
- SYNC_CNT=4, all 8 lanes drive valid=1 with SYNC_PATTERN for 4 cycles -> run_lane=8'hFF at the edge after the 4th beat, lanes_locked_cnt=8, sync_timeout stays 0.
- Lane 3 sends match,match,mismatch then 4 matches, other lanes send matches throughout -> run_lane=8'hF7 after beat 4; lane 3 reaches SEARCH on beat 3 and locks after beat 7, giving run_lane=8'hFF.
- Lane 0 sends match, valid low for 10 cycles, then 3 matches -> lane 0 locks after the 4th valid match; the gaps do not reset the count.
- Lanes 0-6 lock, lane 7 sends mismatches; TIMEOUT_CYC=16 -> sync_timeout pulses exactly 1 cycle, 16 cycles after run_lane=8'h7F first appears, and run_lane=8'h00 on that same edge.
- All lanes locked, retrain high 1 cycle -> run_lane=8'h00 next edge, no sync_timeout; lanes relock after 4 new match beats.
- Assert dlx_reset_n low asynchronously mid-COUNT, and again with run_lane=8'hFF -> run_lane=0, sync_timeout=0 and lanes_locked_cnt=0 without waiting for a clock edge; after release, locking requires a full 4 fresh match beats.

Source files
------------

// File: rtl/ocx_dlx_rx_lane_sync_det_if.sv
// Lane receive bundle between the PHY-side lane feed and the sync detector.
// The master drives lane beats and retrain; the slave returns lock status.
interface ocx_dlx_rx_lane_sync_det_if #(
    parameter int DW = 32
);
    logic [7:0]      ln_rx_valid;
    logic [8*DW-1:0] ln_rx_data;
    logic            retrain;
    logic [7:0]      pb_io_o0_rx_run_lane;
    logic            sync_timeout;
    logic [3:0]      lanes_locked_cnt;

    modport master (
        output ln_rx_valid,
        output ln_rx_data,
        output retrain,
        input  pb_io_o0_rx_run_lane,
        input  sync_timeout,
        input  lanes_locked_cnt
    );

    modport slave (
        input  ln_rx_valid,
        input  ln_rx_data,
        input  retrain,
        output pb_io_o0_rx_run_lane,
        output sync_timeout,
        output lanes_locked_cnt
    );
endinterface

// File: rtl/ocx_dlx_rx_lane_sync_det.sv
// Per-lane sync-pattern lock detector with lane-to-lane lock timeout.
// A lane locks after SYNC_CNT consecutive matching valid beats.
module ocx_dlx_rx_lane_sync_det #(
    parameter int            DW           = 32,
    parameter logic [DW-1:0] SYNC_PATTERN = 32'h4B4B_4B4B,
    parameter int            SYNC_CNT     = 4,
    parameter int            TIMEOUT_CYC  = 1024
) (
    input  logic opt_gckn,
    input  logic dlx_reset_n,
    ocx_dlx_rx_lane_sync_det_if.slave bus
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } lane_st_e;

    localparam logic [3:0]  LOCK_CNT = 4'(SYNC_CNT);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    lane_st_e    st_q  [8];
    lane_st_e    st_d  [8];
    logic [3:0]  cnt_q [8];
    logic [3:0]  cnt_d [8];
    logic [15:0] timer_q, timer_d;
    logic        to_q, to_d;
    logic [7:0]  run_lane;
    logic [7:0]  match;
    logic [3:0]  pop;
    logic        partial, timeout_clear, gclr;

    always_comb begin
        run_lane = '0;
        match    = '0;
        pop      = '0;
        for (int i = 0; i < 8; i++) begin
            run_lane[i] = (st_q[i] == LOCKED);
            match[i]    = bus.ln_rx_valid[i] &&
                          (bus.ln_rx_data[i*DW +: DW] == SYNC_PATTERN);
            pop         = pop + {3'b000, run_lane[i]};
        end
    end

    // Timeout is judged on the pre-edge lock vector, so a lane that
    // completes lock on the expiry cycle is still cleared with the rest.
    always_comb begin
        partial       = (run_lane != 8'h00) && (run_lane != 8'hFF);
        timeout_clear = partial && (timer_q == TMO_LAST);
        gclr          = bus.retrain || timeout_clear;
        to_d          = timeout_clear && !bus.retrain;
        timer_d       = '0;
        if (!gclr && partial) timer_d = timer_q + 16'd1;
        for (int i = 0; i < 8; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (gclr) begin
                st_d[i]  = SEARCH;
                cnt_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    SEARCH: begin
                        if (match[i]) begin
                            cnt_d[i] = 4'd1;
                            st_d[i]  = (LOCK_CNT == 4'd1) ? LOCKED : COUNT;
                        end
                    end
                    COUNT: begin
                        if (match[i]) begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                            if (cnt_q[i] + 4'd1 == LOCK_CNT) st_d[i] = LOCKED;
                        end else if (bus.ln_rx_valid[i]) begin
                            cnt_d[i] = '0;
                            st_d[i]  = SEARCH;
                        end
                    end
                    LOCKED: begin
                        st_d[i] = LOCKED;
                    end
                    default: begin
                        st_d[i]  = SEARCH;
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge opt_gckn or negedge dlx_reset_n) begin
        if (!dlx_reset_n) begin
            for (int i = 0; i < 8; i++) begin
                st_q[i]  <= SEARCH;
                cnt_q[i] <= '0;
            end
            timer_q <= '0;
            to_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            timer_q <= timer_d;
            to_q    <= to_d;
        end
    end

    assign bus.pb_io_o0_rx_run_lane = run_lane;
    assign bus.sync_timeout         = to_q;
    assign bus.lanes_locked_cnt     = pop;
endmodule

// File: tb/tb_ocx_dlx_rx_lane_sync_det.sv
// Directed bench for the lane sync detector with SYNC_CNT=4, TIMEOUT_CYC=16.
// Each task drives one scenario and compares against hand-derived values.
module tb_ocx_dlx_rx_lane_sync_det;
    localparam logic [31:0] PAT = 32'h4B4B_4B4B;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ocx_dlx_rx_lane_sync_det_if #(.DW(32)) bus ();

    ocx_dlx_rx_lane_sync_det #(
        .DW(32),
        .SYNC_PATTERN(PAT),
        .SYNC_CNT(4),
        .TIMEOUT_CYC(16)
    ) dut (
        .opt_gckn(clk),
        .dlx_reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic [7:0] m);
        for (int i = 0; i < 8; i++)
            bus.ln_rx_data[i*32 +: 32] = m[i] ? PAT : ~PAT;
        bus.ln_rx_valid = v;
    endtask

    task automatic clear_all();
        drive(8'h00, 8'h00);
        bus.retrain = 1'b1;
        tick();
        bus.retrain = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.retrain = 1'b0;
        drive(8'h00, 8'h00);
        #12;
        checks++;
        if (bus.pb_io_o0_rx_run_lane !== 8'h00) begin
            failures++;
            $display("FAIL reset_run: got %h expected 00", bus.pb_io_o0_rx_run_lane);
        end
        checks++;
        if (bus.sync_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_to: got %b expected 0", bus.sync_timeout);
        end
        checks++;
        if (bus.lanes_locked_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.lanes_locked_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_lanes();
        drive(8'hFF, 8'hFF);
        for (int b = 1; b <= 4; b++) begin
            tick();
            checks++;
            if (bus.pb_io_o0_rx_run_lane !== (b == 4 ? 8'hFF : 8'h00)) begin
                failures++;
                $display("FAIL all_run beat%0d: got %h", b, bus.pb_io_o0_rx_run_lane);
            end
            checks++;
            if (bus.sync_timeout !== 1'b0) begin
                failures++;
                $display("FAIL all_to beat%0d: got %b expected 0", b, bus.sync_timeout);
            end
        end
        checks++;
        if (bus.lanes_locked_cnt !== 4'd8) begin
            failures++;
            $display("FAIL all_cnt: got %0d expected 8", bus.lanes_locked_cnt);
        end
    endtask

    task automatic test_retrain();
        logic [7:0] exp;
        drive(8'hFF, 8'hFF);
        bus.retrain = 1'b1;
        tick();
        checks++;
        if (bus.pb_io_o0_rx_run_lane !== 8'h00 || bus.sync_timeout !== 1'b0) begin
            failures++;
            $display("FAIL retrain_clr: run %h to %b expected 00/0",
                     bus.pb_io_o0_rx_run_lane, bus.sync_timeout);
        end
        tick();
        tick();
        checks++;
        if (bus.pb_io_o0_rx_run_lane !== 8'h00) begin
            failures++;
            $display("FAIL retrain_hold: got %h expected 00", bus.pb_io_o0_rx_run_lane);
        end
        bus.retrain = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            tick();
            exp = (b == 4) ? 8'hFF : 8'h00;
            checks++;
            if (bus.pb_io_o0_rx_run_lane !== exp) begin
                failures++;
                $display("FAIL retrain_relock beat%0d: got %h expected %h",
                         b, bus.pb_io_o0_rx_run_lane, exp);
            end
        end
    endtask

    task automatic test_lane3_mismatch();
        logic [7:0] exp;
        logic [7:0] m3;
        clear_all();
        for (int b = 1; b <= 7; b++) begin
            m3 = (b == 3) ? 8'hF7 : 8'hFF;
            drive(8'hFF, m3);
            tick();
            exp = (b >= 7) ? 8'hFF : (b >= 4 ? 8'hF7 : 8'h00);
            checks++;
            if (bus.pb_io_o0_rx_run_lane !== exp) begin
                failures++;
                $display("FAIL lane3 beat%0d: got %h expected %h",
                         b, bus.pb_io_o0_rx_run_lane, exp);
            end
        end
        checks++;
        if (bus.lanes_locked_cnt !== 4'd8) begin
            failures++;
            $display("FAIL lane3_cnt: got %0d expected 8", bus.lanes_locked_cnt);
        end
    endtask

    task automatic test_gaps();
        clear_all();
        drive(8'h01, 8'h01);
        tick();
        drive(8'h00, 8'h01);
        repeat (10) tick();
        drive(8'h01, 8'h01);
        tick();
        tick();
        checks++;
        if (bus.pb_io_o0_rx_run_lane !== 8'h00) begin
            failures++;
            $display("FAIL gap_early: got %h expected 00", bus.pb_io_o0_rx_run_lane);
        end
        tick();
        checks++;
        if (bus.pb_io_o0_rx_run_lane !== 8'h01 || bus.lanes_locked_cnt !== 4'd1) begin
            failures++;
            $display("FAIL gap_lock: run %h cnt %0d expected 01/1",
                     bus.pb_io_o0_rx_run_lane, bus.lanes_locked_cnt);
        end
        clear_all();
    endtask

    task automatic test_timeout(input logic with_retrain);
        logic exp_to;
        clear_all();
        drive(8'hFF, 8'h7F);
        repeat (4) tick();
        checks++;
        if (bus.pb_io_o0_rx_run_lane !== 8'h7F) begin
            failures++;
            $display("FAIL tmo_start: got %h expected 7F", bus.pb_io_o0_rx_run_lane);
        end
        for (int k = 1; k <= 15; k++) begin
            if (k == 15 && with_retrain) bus.retrain = 1'b1;
            tick();
            if (bus.sync_timeout !== 1'b0 || bus.pb_io_o0_rx_run_lane !== 8'h7F) begin
                if (k != 15 || !with_retrain) begin
                    failures++;
                    $display("FAIL tmo_wait k%0d: run %h to %b",
                             k, bus.pb_io_o0_rx_run_lane, bus.sync_timeout);
                end
            end
            if (k != 15 || !with_retrain) checks++;
        end
        if (!with_retrain) begin
            drive(8'h00, 8'h00);
            tick();
        end
        exp_to = !with_retrain;
        checks++;
        if (bus.sync_timeout !== exp_to || bus.pb_io_o0_rx_run_lane !== 8'h00) begin
            failures++;
            $display("FAIL tmo_fire rt%0b: run %h to %b expected 00/%b",
                     with_retrain, bus.pb_io_o0_rx_run_lane, bus.sync_timeout, exp_to);
        end
        bus.retrain = 1'b0;
        drive(8'h00, 8'h00);
        tick();
        checks++;
        if (bus.sync_timeout !== 1'b0 || bus.pb_io_o0_rx_run_lane !== 8'h00) begin
            failures++;
            $display("FAIL tmo_after rt%0b: run %h to %b expected 00/0",
                     with_retrain, bus.pb_io_o0_rx_run_lane, bus.sync_timeout);
        end
    endtask

    task automatic test_async_reset(input int pre_beats);
        logic [7:0] exp;
        clear_all();
        drive(8'hFF, 8'hFF);
        repeat (pre_beats) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pb_io_o0_rx_run_lane !== 8'h00 || bus.sync_timeout !== 1'b0 ||
            bus.lanes_locked_cnt !== 4'd0) begin
            failures++;
            $display("FAIL arst pre%0d: run %h to %b cnt %0d expected 00/0/0",
                     pre_beats, bus.pb_io_o0_rx_run_lane, bus.sync_timeout,
                     bus.lanes_locked_cnt);
        end
        #1;
        rst_n = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            tick();
            exp = (b == 4) ? 8'hFF : 8'h00;
            checks++;
            if (bus.pb_io_o0_rx_run_lane !== exp) begin
                failures++;
                $display("FAIL arst_relock pre%0d beat%0d: got %h expected %h",
                         pre_beats, b, bus.pb_io_o0_rx_run_lane, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        bus.retrain = 1'b0;
        bus.ln_rx_valid = '0;
        bus.ln_rx_data = '0;
        test_reset();
        test_all_lanes();
        test_retrain();
        test_lane3_mismatch();
        test_gaps();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_async_reset(2);
        test_async_reset(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
